brcomp: RTL and testbench

BRCOMP -- requirements
Module: brcomp

---
 rtl/brcomp_if.sv | 24 ++
 rtl/brcomp.sv | 63 ++++++
 tb/tb_brcomp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/brcomp_if.sv
// Branch-compare bus: operands and mode in, combinational and registered flags out.
interface brcomp_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              I_U;
  logic              less;
  logic              equal;
  logic              less_q;
  logic              equal_q;

  // Driver side: supplies operands and mode, observes the flags.
  modport master (
    output rs1_data, rs2_data, I_U,
    input  less, equal, less_q, equal_q
  );

  // Comparator side: consumes operands and mode, produces the flags.
  modport slave (
    input  rs1_data, rs2_data, I_U,
    output less, equal, less_q, equal_q
  );
endinterface

// File: rtl/brcomp.sv
// Branch comparator: signed/unsigned less-than and equality flags, available
// combinationally and as a one-cycle registered copy.
module brcomp #(
  parameter int DATA_W = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  brcomp_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] lhs;
  logic [DATA_W-1:0] rhs_n;
  logic              carry_out;
  logic              less_u;
  logic              sign_diff;
  logic              less_c;
  logic              equal_c;

  assign lhs   = bus.rs1_data;
  assign rhs_n = ~bus.rs2_data;

  // Ripple carry chain of lhs + ~rhs + 1; only the carry-out is needed.
  always_comb begin
    logic carry;
    // NOTE: blocking assignments here are intentional; carry is a chain of
    // combinational values evaluated in loop order, not stored state.
    carry = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      carry = (lhs[i] & rhs_n[i]) | (carry & (lhs[i] ^ rhs_n[i]));
    end
    carry_out = carry;
  end

  // No carry-out means the subtraction borrowed, i.e. lhs < rhs unsigned.
  assign less_u = ~carry_out;

  // With differing signs the negative operand is the smaller one; with equal
  // signs the two's-complement order matches the unsigned order.
  assign sign_diff = lhs[MSB] ^ bus.rs2_data[MSB];
  assign less_c    = bus.I_U ? less_u : (sign_diff ? lhs[MSB] : less_u);

  // Equality as the AND of per-bit XNORs.
  assign equal_c = &(lhs ~^ bus.rs2_data);

  assign bus.less  = less_c;
  assign bus.equal = equal_c;

  // Registered copies of the flags, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the reset branch sits in the sensitivity list so the flags clear
    // the moment rst_n falls, without waiting for a clock edge.
    if (!rst_n) begin
      bus.less_q  <= 1'b0;
      bus.equal_q <= 1'b0;
    end else begin
      bus.less_q  <= less_c;
      bus.equal_q <= equal_c;
    end
  end

endmodule

// File: tb/tb_brcomp.sv
// Scoreboard bench for brcomp: stimulus pushes model expectations into queues,
// independent monitors pop and compare the combinational and registered flags.
module tb_brcomp;

  typedef struct packed {
    logic less;
    logic equal;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   reg_en;
  event stim_ev;

  exp_t comb_q[$];
  exp_t reg_q[$];

  brcomp_if #(.DATA_W(32)) bus ();

  brcomp #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ordering taken straight from the numeric meaning of the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic iu);
    exp_t e;
    e.equal = (a == b);
    if (iu) e.less = (a < b);
    else    e.less = ($signed(a) < $signed(b));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one operand set at the falling edge and post its expectations.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic iu);
    exp_t e;
    @(negedge clk);
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.I_U      = iu;
    e = model(a, b, iu);
    comb_q.push_back(e);
    if (reg_en) reg_q.push_back(e);
    ->stim_ev;
  endtask

  // Combinational monitor: flags must match 1 ns after each new input set.
  initial begin
    exp_t e;
    forever begin
      @(stim_ev);
      #1;
      if (comb_q.size() == 0) begin
        check("comb_queue_underflow", 32'd0, 32'd1);
      end else begin
        e = comb_q.pop_front();
        check("less",  {31'd0, bus.less},  {31'd0, e.less});
        check("equal", {31'd0, bus.equal}, {31'd0, e.equal});
        check("less_and_equal_exclusive", {31'd0, bus.less & bus.equal}, 32'd0);
      end
    end
  end

  // Registered monitor: each rising edge captures the last applied set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_en && rst_n && reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check("less_q",  {31'd0, bus.less_q},  {31'd0, e.less});
        check("equal_q", {31'd0, bus.equal_q}, {31'd0, e.equal});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks   = 0;
    failures = 0;
    reg_en   = 1'b0;
    rst_n    = 1'b0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.I_U      = 1'b0;

    // Reset state, and combinational flags working while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("reset_less_q",  {31'd0, bus.less_q},  32'd0);
    check("reset_equal_q", {31'd0, bus.equal_q}, 32'd0);
    apply(32'h0000_0010, 32'h0000_0010, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    apply(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    apply(32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    #2;
    check("held_in_reset_less_q", {31'd0, bus.less_q}, 32'd0);

    // First edge after release loads live values; mid-cycle changes wait for the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_0001, 32'h0000_0002, 1'b1);
    @(posedge clk);
    #1;
    check("first_edge_less_q",  {31'd0, bus.less_q},  32'd1);
    check("first_edge_equal_q", {31'd0, bus.equal_q}, 32'd0);
    #2;
    bus.rs1_data = 32'h0000_0005;
    bus.rs2_data = 32'h0000_0005;
    #1;
    check("midcycle_equal",   {31'd0, bus.equal},   32'd1);
    check("midcycle_less_q",  {31'd0, bus.less_q},  32'd1);
    check("midcycle_equal_q", {31'd0, bus.equal_q}, 32'd0);
    @(posedge clk);
    #1;
    check("next_edge_less_q",  {31'd0, bus.less_q},  32'd0);
    check("next_edge_equal_q", {31'd0, bus.equal_q}, 32'd1);

    // Registered path through the monitor, then a mid-operation reset.
    reg_en = 1'b1;
    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reg_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset_less_q",  {31'd0, bus.less_q},  32'd0);
    check("async_reset_equal_q", {31'd0, bus.equal_q}, 32'd0);
    check("reset_keeps_less",    {31'd0, bus.less},    32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    reg_en = 1'b1;

    // Sign boundaries, including a change of I_U alone.
    apply(32'h8000_0000, 32'h0000_0000, 1'b0);
    apply(32'h8000_0000, 32'h0000_0000, 1'b1);
    apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

    // Random operand pairs with a bias toward equal and near-equal values.
    for (int n = 0; n < 10000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        2:       b = a + 32'd1;
        3:       b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      apply(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    reg_en = 1'b0;
    check("comb_queue_drained", comb_q.size(), 32'd0);
    check("reg_queue_drained",  reg_q.size(),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
